note_sequencer: RTL and testbench



---
 rtl/note_seq_pkg.sv | 27 ++
 rtl/note_sequencer_if.sv | 19 +
 rtl/note_window.sv | 53 +++++
 rtl/note_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_note_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/note_seq_pkg.sv
// ---------------------------------------------------------------------------
// note_seq_pkg
// Shared definitions for the note sequencer:
//   state_t      - sequencer FSM state (also exported on state_out)
//   MODE_TIMED   - window advances on a fixed note period
//   MODE_LEARN   - window advances on external advance pulses
//   finish_note  - all-ones note code that marks the end of a song
// ---------------------------------------------------------------------------
package note_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic MODE_TIMED = 1'b0;
    localparam logic MODE_LEARN = 1'b1;

    // All-ones code of the given width; callers cast to their note width.
    function automatic logic [63:0] finish_note(input int bits);
        return (bits >= 64) ? {64{1'b1}} : ((64'd1 << bits) - 64'd1);
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// ---------------------------------------------------------------------------
// note_sequencer_if
// Note ROM bus between the sequencer (master) and the BRAM (slave).
//   rom_addr_out - registered read address driven by the sequencer
//   rom_data_in  - note word returned by the ROM
// Handshake: there is no valid/ready pair on this bus. The ROM has a fixed
// read latency: rom_data_in is valid on the second rising edge after
// rom_addr_out changes, and the sequencer never samples it earlier.
// ---------------------------------------------------------------------------
interface note_sequencer_if #(
    parameter int ADDR_BITS = 10,
    parameter int NOTE_BITS = 7
);
    logic [ADDR_BITS-1:0] rom_addr_out;
    logic [NOTE_BITS-1:0] rom_data_in;

    modport master (output rom_addr_out, input rom_data_in);
    modport slave  (input rom_addr_out, output rom_data_in);
endinterface

// File: rtl/note_window.sv
// ---------------------------------------------------------------------------
// note_window
// WINDOW x NOTE_BITS shift register holding the visible notes.
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - synchronous clear of every slot to 0 (wins over shift_en)
//   shift_en    - shift the window one slot towards the MSBs
//   shift_data  - note entering the LSB slot on a shift
//   notes       - window contents, head (oldest note) in the MSBs
// ---------------------------------------------------------------------------
module note_window #(
    parameter int NOTE_BITS = 7,
    parameter int WINDOW    = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        shift_en,
    input  logic [NOTE_BITS-1:0]        shift_data,
    output logic [WINDOW*NOTE_BITS-1:0] notes
);
    localparam int WIDTH = WINDOW * NOTE_BITS;

    logic [WIDTH-1:0] win_q;

    // A one-slot window has no older notes to keep, so it gets its own
    // register to avoid an empty slice.
    generate
        if (WINDOW == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    win_q <= '0;
                end else if (clear) begin
                    win_q <= '0;
                end else if (shift_en) begin
                    win_q <= shift_data;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    win_q <= '0;
                end else if (clear) begin
                    win_q <= '0;
                end else if (shift_en) begin
                    win_q <= {win_q[WIDTH-NOTE_BITS-1:0], shift_data};
                end
            end
        end
    endgenerate

    assign notes = win_q;

endmodule

// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
// Streams a song from the note ROM into a look-ahead window. After a start
// pulse the window is preloaded (busy_out), then advances every NOTE_CYCLES
// clocks (timed mode) or on advance_in (learn mode). pause_in holds the
// window, the finish note at the head ends the song (done_out), and reads
// never leave the selected song's region.
// Ports:
//   clk_in, rst_n_in  - clock, asynchronous active-low reset
//   start_in          - (re)start pulse, latches song_in and mode_in
//   song_in, mode_in  - song select, 0 = timed / 1 = learn
//   pause_in          - level, holds the window while high
//   advance_in        - learn-mode advance request
//   rom               - ROM bus (registered address out, data in)
//   notes_out         - note window, head in the MSBs
//   shift_out         - one-cycle pulse per window shift
//   busy_out, done_out- preload in progress / song finished
//   note_index_out    - run-phase shifts since start
//   state_out         - FSM state for debug
// ---------------------------------------------------------------------------
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int NOTE_BITS   = 7,
    parameter int WINDOW      = 5,
    parameter int ADDR_BITS   = 10,
    parameter int SONG_BITS   = 2,
    parameter int SONG_STRIDE = 250,
    parameter int NOTE_CYCLES = 50_000_000,
    parameter int CNT_BITS    = 26
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        start_in,
    input  logic [SONG_BITS-1:0]        song_in,
    input  logic                        mode_in,
    input  logic                        pause_in,
    input  logic                        advance_in,
    note_sequencer_if.master            rom,
    output logic [WINDOW*NOTE_BITS-1:0] notes_out,
    output logic                        shift_out,
    output logic                        busy_out,
    output logic                        done_out,
    output logic [ADDR_BITS-1:0]        note_index_out,
    output logic [2:0]                  state_out
);
    localparam logic [NOTE_BITS-1:0] FINISH     = NOTE_BITS'(finish_note(NOTE_BITS));
    localparam logic [CNT_BITS-1:0]  TIMER_LAST = CNT_BITS'(NOTE_CYCLES - 1);
    localparam int                   PCW        = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [PCW-1:0]       PRE_LAST   = PCW'(WINDOW - 1);
    localparam logic [ADDR_BITS-1:0] STRIDE     = ADDR_BITS'(SONG_STRIDE);

    state_t               state_q, state_d;
    logic                 phase_q, phase_d;      // preload: 0 = wait, 1 = capture
    logic [PCW-1:0]       pre_cnt_q, pre_cnt_d;  // captures done so far
    logic [CNT_BITS-1:0]  timer_q, timer_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS-1:0] end_q, end_d;          // first address past the song
    logic                 mode_q, mode_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic                 pend_q;                // ROM read after a shift not yet valid
    logic                 shift_q;

    logic                 win_clear;
    logic                 win_shift;
    logic                 run_shift;
    logic                 at_end;
    logic [NOTE_BITS-1:0] shift_data;
    logic [NOTE_BITS-1:0] head;
    logic [ADDR_BITS-1:0] song_base;
    logic [WINDOW*NOTE_BITS-1:0] notes;

    assign song_base  = ADDR_BITS'(song_in) * STRIDE;
    assign head       = notes[WINDOW*NOTE_BITS-1 -: NOTE_BITS];
    // Once the address sits on the word past the song, the ROM data is not
    // part of this song; the finish note is inserted instead.
    assign at_end     = (addr_q == end_q);
    assign shift_data = at_end ? FINISH : rom.rom_data_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_IDLE;
            phase_q   <= 1'b0;
            pre_cnt_q <= '0;
            timer_q   <= '0;
            addr_q    <= '0;
            end_q     <= '0;
            mode_q    <= MODE_TIMED;
            idx_q     <= '0;
            pend_q    <= 1'b0;
            shift_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            pre_cnt_q <= pre_cnt_d;
            timer_q   <= timer_d;
            addr_q    <= addr_d;
            end_q     <= end_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            pend_q    <= win_shift;
            shift_q   <= win_shift;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        pre_cnt_d = pre_cnt_q;
        timer_d   = timer_q;
        addr_d    = addr_q;
        end_d     = end_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        win_clear = 1'b0;
        win_shift = 1'b0;
        run_shift = 1'b0;

        if (start_in) begin
            state_d   = ST_PRELOAD;
            phase_d   = 1'b0;
            pre_cnt_d = '0;
            timer_d   = '0;
            addr_d    = song_base;
            end_d     = song_base + STRIDE;
            mode_d    = mode_in;
            idx_d     = '0;
            win_clear = 1'b1;
        end else begin
            case (state_q)
                ST_PRELOAD: begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d   = 1'b0;
                        win_shift = 1'b1;
                        if (pre_cnt_q == PRE_LAST) begin
                            state_d = pause_in ? ST_PAUSED : ST_RUN;
                            timer_d = '0;
                        end else begin
                            pre_cnt_d = pre_cnt_q + 1'b1;
                        end
                    end
                end
                // PAUSED with pause_in low behaves as a RUN cycle, so the
                // timer keeps counting from its frozen value and the note
                // period excludes only cycles with pause_in high.
                ST_RUN, ST_PAUSED: begin
                    if (head == FINISH) begin
                        state_d = ST_DONE;
                    end else if (pause_in) begin
                        state_d = ST_PAUSED;
                    end else begin
                        state_d = ST_RUN;
                        if (mode_q == MODE_TIMED) begin
                            if (timer_q == TIMER_LAST) begin
                                timer_d   = '0;
                                run_shift = 1'b1;
                            end else begin
                                timer_d = timer_q + 1'b1;
                            end
                        end else if (advance_in && !pend_q) begin
                            run_shift = 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (run_shift) begin
                win_shift = 1'b1;
                idx_d     = idx_q + 1'b1;
            end
            if (win_shift && !at_end) begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    note_window #(
        .NOTE_BITS (NOTE_BITS),
        .WINDOW    (WINDOW)
    ) u_window (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .clear      (win_clear),
        .shift_en   (win_shift),
        .shift_data (shift_data),
        .notes      (notes)
    );

    assign rom.rom_addr_out = addr_q;
    assign notes_out        = notes;
    assign shift_out        = shift_q;
    assign busy_out         = (state_q == ST_PRELOAD);
    assign done_out         = (state_q == ST_DONE);
    assign note_index_out   = idx_q;
    assign state_out        = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// ---------------------------------------------------------------------------
// tb_note_sequencer
// Drives two sequencers (song stride 250 and stride 6) from shared inputs.
// The first is compared every cycle against a reference model that tracks
// only how many notes of the song have been inserted; window contents and
// ROM address follow from that count. The second covers the song bound.
// ---------------------------------------------------------------------------
module tb_note_sequencer;
    import note_seq_pkg::*;

    localparam int NB       = 7;
    localparam int W        = 5;
    localparam int AB       = 10;
    localparam int SB       = 2;
    localparam int NC       = 4;
    localparam int CB       = 2;
    localparam int STRIDE   = 250;
    localparam int STRIDE_B = 6;
    localparam int WB       = W * NB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [SB-1:0] song = '0;
    logic mode = 1'b0;
    logic pause = 1'b0;
    logic adv = 1'b0;

    logic [WB-1:0] notes, notes_b;
    logic shift, busy, done, shift_b, busy_b, done_b;
    logic [AB-1:0] idx, idx_b;
    logic [2:0] st, st_b;

    int n_checks = 0;
    int n_fail = 0;
    int fin_addr = -1;

    note_sequencer_if #(.ADDR_BITS(AB), .NOTE_BITS(NB)) rom_a ();
    note_sequencer_if #(.ADDR_BITS(AB), .NOTE_BITS(NB)) rom_b ();

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    note_sequencer #(
        .NOTE_BITS(NB), .WINDOW(W), .ADDR_BITS(AB), .SONG_BITS(SB),
        .SONG_STRIDE(STRIDE), .NOTE_CYCLES(NC), .CNT_BITS(CB)
    ) u_dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .song_in(song),
        .mode_in(mode), .pause_in(pause), .advance_in(adv), .rom(rom_a),
        .notes_out(notes), .shift_out(shift), .busy_out(busy), .done_out(done),
        .note_index_out(idx), .state_out(st)
    );

    note_sequencer #(
        .NOTE_BITS(NB), .WINDOW(W), .ADDR_BITS(AB), .SONG_BITS(SB),
        .SONG_STRIDE(STRIDE_B), .NOTE_CYCLES(NC), .CNT_BITS(CB)
    ) u_dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .song_in(song),
        .mode_in(mode), .pause_in(pause), .advance_in(adv), .rom(rom_b),
        .notes_out(notes_b), .shift_out(shift_b), .busy_out(busy_b), .done_out(done_b),
        .note_index_out(idx_b), .state_out(st_b)
    );

    // ROM content: word a holds a[6:0], except an optional planted finish note.
    function automatic logic [NB-1:0] rom_word(input int a);
        if (a == fin_addr) return {NB{1'b1}};
        return NB'(a);
    endfunction

    // BRAM with registered address: two edges from address change to data.
    always @(posedge clk) begin
        rom_a.rom_data_in <= rom_word(int'(rom_a.rom_addr_out));
        rom_b.rom_data_in <= rom_b.rom_addr_out[NB-1:0];
    end

    // ---------------- reference model ----------------
    int m_phase;   // 0 idle, 1 preload, 2 run (incl. paused), 3 done
    int m_cnt;     // preload cycles elapsed
    int m_n;       // notes inserted into the window since start
    int m_base;
    int m_learn;
    int m_tick;    // unpaused run cycles since last shift
    int m_cool;    // a shift happened last cycle
    int m_idx;
    int m_shift;

    function automatic logic [NB-1:0] song_note(input int k);
        if (k >= STRIDE) return {NB{1'b1}};
        return rom_word(m_base + k);
    endfunction

    function automatic logic [WB-1:0] exp_window();
        logic [WB-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            int j;
            j = m_n - W + i;
            if (j >= 0) w[(W-1-i)*NB +: NB] = song_note(j);
        end
        return w;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_n = 0; m_base = 0; m_learn = 0;
        m_tick = 0; m_cool = 0; m_idx = 0; m_shift = 0;
    endtask

    task automatic model_step();
        int sh;
        sh = 0;
        if (start) begin
            m_phase = 1; m_cnt = 0; m_n = 0; m_base = int'(song) * STRIDE;
            m_learn = int'(mode); m_tick = 0; m_idx = 0;
        end else if (m_phase == 1) begin
            m_cnt++;
            if (m_cnt % 2 == 0) begin m_n++; sh = 1; end
            if (m_cnt == 2 * W) begin m_phase = 2; m_tick = 0; end
        end else if (m_phase == 2) begin
            if (m_n >= W && song_note(m_n - W) == {NB{1'b1}}) begin
                m_phase = 3;
            end else if (!pause) begin
                if (m_learn == 0) begin
                    if (m_tick == NC - 1) begin sh = 1; m_tick = 0; end
                    else m_tick++;
                end else if (adv && m_cool == 0) begin
                    sh = 1;
                end
                if (sh != 0) begin m_n++; m_idx++; end
            end
        end
        m_shift = sh;
        m_cool = sh;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("busy", 64'(busy), 64'(m_phase == 1));
        check("done", 64'(done), 64'(m_phase == 3));
        check("shift", 64'(shift), 64'(m_shift));
        check("notes", 64'(notes), 64'(exp_window()));
        check("index", 64'(idx), 64'(m_idx));
        check("addr", 64'(rom_a.rom_addr_out), 64'(m_base + ((m_n < STRIDE) ? m_n : STRIDE)));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_start(input int s, input logic md);
        song = SB'(s); mode = md; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_preload(input string tag);
        int bc;
        bc = 0;
        while (busy && bc < 40) begin bc++; tick(); end
        check(tag, 64'(bc), 64'(2 * W));
    endtask

    task automatic wait_shift(output int n);
        n = 0;
        do begin tick(); n++; end while (!shift && n < 50);
        check("wait_shift", 64'(shift), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_notes"}, 64'(notes), 64'd0);
        check({tag, "_addr"}, 64'(rom_a.rom_addr_out), 64'd0);
        check({tag, "_shift"}, 64'(shift), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_index"}, 64'(idx), 64'd0);
        check({tag, "_state"}, 64'(st), 64'(ST_IDLE));
        check({tag, "_b_addr"}, 64'(rom_b.rom_addr_out), 64'd0);
        check({tag, "_b_notes"}, 64'(notes_b), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WB-1:0] e;
        logic [WB-1:0] frozen;
        int d, sc, k, prev_b, seen, max_b;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();

        // Song 1, timed: preload length, window content, shift period.
        do_start(1, MODE_TIMED);
        wait_preload("busy_len_song1");
        e = '0;
        for (int i = 0; i < W; i++) e[(W-1-i)*NB +: NB] = NB'(250 + i);
        check("preload_window", 64'(notes), 64'(e));
        wait_shift(d);
        check("first_gap", 64'(d), 64'(NC));
        for (int i = 0; i < 3; i++) begin
            wait_shift(d);
            check("shift_gap", 64'(d), 64'(NC));
        end

        // Pause for 7 cycles at timer value 2.
        do_start(2, MODE_TIMED);
        wait_preload("busy_len_song2");
        tick(); tick();
        pause = 1'b1;
        sc = 0;
        repeat (7) begin tick(); if (shift) sc++; end
        check("pause_shifts", 64'(sc), 64'd0);
        pause = 1'b0;
        wait_shift(d);
        check("resume_gap", 64'(d), 64'd2);

        // Learn mode: back-to-back pulses give one shift.
        do_start(0, MODE_LEARN);
        wait_preload("busy_len_learn1");
        tick();
        adv = 1'b1; tick(); tick();
        adv = 1'b0; tick(); tick();
        check("learn_pair_adjacent", 64'(idx), 64'd1);

        // Learn mode: pulses two cycles apart give two shifts.
        do_start(0, MODE_LEARN);
        wait_preload("busy_len_learn2");
        tick();
        adv = 1'b1; tick();
        adv = 1'b0; tick();
        adv = 1'b1; tick();
        adv = 1'b0; tick(); tick();
        check("learn_pair_spaced", 64'(idx), 64'd2);

        // Finish note planted at offset 3 of song 1.
        fin_addr = 250 + 3;
        do_start(1, MODE_TIMED);
        wait_preload("busy_len_fin");
        k = 0;
        while (notes[WB-1 -: NB] != {NB{1'b1}} && k < 100) begin tick(); k++; end
        check("fin_head", 64'(notes[WB-1 -: NB]), 64'h7f);
        check("done_before", 64'(done), 64'd0);
        tick();
        check("done_rise", 64'(done), 64'd1);
        frozen = notes;
        adv = 1'b1;
        sc = 0;
        repeat (3 * NC) begin tick(); if (shift) sc++; end
        adv = 1'b0;
        check("frozen_notes", 64'(notes), 64'(frozen));
        check("done_no_shift", 64'(sc), 64'd0);
        do_start(1, MODE_TIMED);
        check("restart_busy", 64'(busy), 64'd1);
        wait_preload("busy_len_restart");

        // Song bound on the stride-6 instance.
        fin_addr = -1;
        do_start(0, MODE_TIMED);
        k = 0; seen = 0; max_b = 0;
        while (!done_b && k < 200) begin
            prev_b = int'(rom_b.rom_addr_out);
            tick();
            k++;
            if (int'(rom_b.rom_addr_out) > max_b) max_b = int'(rom_b.rom_addr_out);
            if (shift_b && prev_b == STRIDE_B && seen == 0) begin
                seen = 1;
                check("b_finish_in", 64'(notes_b[NB-1:0]), 64'h7f);
            end
        end
        check("b_done", 64'(done_b), 64'd1);
        check("b_addr_hold", 64'(rom_b.rom_addr_out), 64'(STRIDE_B));
        check("b_addr_max", 64'(max_b), 64'(STRIDE_B));
        check("b_notes", 64'(notes_b), 64'({WB{1'b1}}));

        // Asynchronous reset mid-RUN.
        do_start(2, MODE_TIMED);
        wait_preload("busy_len_prereset");
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 79) == 0) begin
                song = SB'($urandom_range(0, 3));
                mode = 1'($urandom_range(0, 1));
                fin_addr = ($urandom_range(0, 1) == 1) ?
                           int'(song) * STRIDE + int'($urandom_range(0, 12)) : -1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            adv = ($urandom_range(0, 2) == 0);
            tick();
        end
        start = 1'b0; pause = 1'b0; adv = 1'b0;
        tick();

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
